// File: rtl/rf_wb_scheduler_pkg.sv
// Shared widths, constants and the write-port request type for the regfile writeback path.
package rf_wb_scheduler_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // One regfile write-port request.
    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  wn;
        logic [DATA_W-1:0] d;
    } wb_req_t;

    // One-hot mask for a register number; r0 never produces a bit.
    function automatic logic [NUM_REGS-1:0] reg_mask(input logic en, input logic [REG_W-1:0] rn);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (en && rn != ZERO_REG) m[rn] = 1'b1;
        return m;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result bits for r1..r31 plus the RAW/WAW hazard compare for the ID stage.
module rf_scoreboard
    import rf_wb_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                clrn,
    input  logic                set_en,
    input  logic [REG_W-1:0]    set_rn,
    input  logic                clr_en,
    input  logic [REG_W-1:0]    clr_rn,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_wreg,
    output logic                hazard,
    output logic [NUM_REGS-1:0] pending
);
    logic [NUM_REGS-1:0] set_mask, clr_mask, pending_nxt;

    // Clear first, then set, so an issue to the register being retired keeps it pending.
    always_comb begin
        set_mask    = reg_mask(set_en, set_rn);
        clr_mask    = reg_mask(clr_en, clr_rn);
        pending_nxt = (pending & ~clr_mask) | set_mask;
    end

    // Pending bit register; reset drops every in-flight result.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) pending <= '0;
        else       pending <= pending_nxt;
    end

    // Hazard when any used source or the destination is still waiting on the MDU.
    always_comb begin
        hazard = (id_use_rs & pending[id_rs]) |
                 (id_use_rt & pending[id_rt]) |
                 (id_wreg   & pending[id_rd]);
    end
endmodule

// File: rtl/rf_wb_scheduler.sv
// Regfile write-port arbiter (pipeline over MDU), outstanding-op limit and MDU starvation guard.
module rf_wb_scheduler
    import rf_wb_scheduler_pkg::*;
#(
    parameter int MAX_OUT      = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              id_long,
    output logic              id_stall,
    input  logic              pipe_we,
    input  logic [REG_W-1:0]  pipe_wn,
    input  logic [DATA_W-1:0] pipe_d,
    input  logic              md_valid,
    input  logic [REG_W-1:0]  md_wn,
    input  logic [DATA_W-1:0] md_d,
    output logic              md_ready,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_wn,
    output logic [DATA_W-1:0] rf_d
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic                pipe_eff, md_acc, issue, cnt_full, starve_freeze, hazard;
    logic [CNT_W-1:0]    cnt;
    logic [STV_W-1:0]    starve;
    logic [NUM_REGS-1:0] pending;
    wb_req_t             wb_q, wb_nxt;

    // Write-port arbitration and issue control; the pipeline cannot be back-pressured.
    always_comb begin
        pipe_eff      = pipe_we && (pipe_wn != ZERO_REG);
        md_ready      = ~pipe_eff;
        md_acc        = md_valid & md_ready;
        cnt_full      = (cnt == CNT_W'(MAX_OUT));
        starve_freeze = (starve == STV_W'(STARVE_LIMIT));
        id_stall      = id_valid & (hazard | (id_long & cnt_full) | starve_freeze);
        issue         = id_valid & ~id_stall;
    end

    rf_scoreboard u_sb (
        .clk       (clk),
        .clrn      (clrn),
        .set_en    (issue & id_long & id_wreg),
        .set_rn    (id_rd),
        .clr_en    (md_acc),
        .clr_rn    (md_wn),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rd     (id_rd),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .id_wreg   (id_wreg),
        .hazard    (hazard),
        .pending   (pending)
    );

    // Next write-port request; number and data hold when nothing is written.
    always_comb begin
        wb_nxt    = wb_q;
        wb_nxt.we = 1'b0;
        if (pipe_eff) begin
            wb_nxt = '{we: 1'b1, wn: pipe_wn, d: pipe_d};
        end else if (md_valid && md_wn != ZERO_REG) begin
            wb_nxt = '{we: 1'b1, wn: md_wn, d: md_d};
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) wb_q <= '0;
        else       wb_q <= wb_nxt;
    end

    assign rf_we = wb_q.we;
    assign rf_wn = wb_q.wn;
    assign rf_d  = wb_q.d;

    // Outstanding MDU ops: issue and retire in one cycle cancel; never wraps.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if ((issue & id_long) && !md_acc) begin
            if (!cnt_full) cnt <= cnt + CNT_W'(1);
        end else if (md_acc && !(issue & id_long)) begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

    // Starvation counter: counts cycles an MDU result is refused, saturating at the limit.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                       starve <= '0;
        else if (md_valid && !md_ready) starve <= starve_freeze ? starve : starve + STV_W'(1);
        else                             starve <= '0;
    end

    // An MDU result with nothing outstanding is a protocol error.
    a_md_cnt: assert property (@(posedge clk) disable iff (!clrn) md_valid |-> (cnt != '0));

    // WAW is blocked at issue, so the pipeline never writes a pending register.
    a_pipe_pend: assert property (@(posedge clk) disable iff (!clrn) pipe_eff |-> !pending[pipe_wn]);
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: table of per-cycle vectors plus reset and starvation sequences.
module tb_rf_wb_scheduler;
    logic        clk = 1'b0;
    logic        clrn;
    logic        id_valid, id_use_rs, id_use_rt, id_wreg, id_long;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_stall;
    logic        pipe_we;
    logic [4:0]  pipe_wn;
    logic [31:0] pipe_d;
    logic        md_valid;
    logic [4:0]  md_wn;
    logic [31:0] md_d;
    logic        md_ready, rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler #(.MAX_OUT(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .clrn(clrn),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_wreg(id_wreg), .id_rd(id_rd), .id_long(id_long), .id_stall(id_stall),
        .pipe_we(pipe_we), .pipe_wn(pipe_wn), .pipe_d(pipe_d),
        .md_valid(md_valid), .md_wn(md_wn), .md_d(md_d), .md_ready(md_ready),
        .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d)
    );

    typedef struct {
        logic        v, urs, urt, wreg, lng, pwe, mv;
        logic [4:0]  rs, rt, rd, pwn, mwn;
        logic [31:0] pd, md;
        logic        s, r, we;
        logic [4:0]  wn;
        logic [31:0] d;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
        input logic wreg, input logic [4:0] rd, input logic lng,
        input logic pwe, input logic [4:0] pwn, input logic [31:0] pd,
        input logic mv, input logic [4:0] mwn, input logic [31:0] md,
        input logic s, input logic r, input logic we, input logic [4:0] wn, input logic [31:0] d);
        vec_t t;
        t.v = v; t.rs = rs; t.urs = urs; t.rt = rt; t.urt = urt; t.wreg = wreg; t.rd = rd; t.lng = lng;
        t.pwe = pwe; t.pwn = pwn; t.pd = pd; t.mv = mv; t.mwn = mwn; t.md = md;
        t.s = s; t.r = r; t.we = we; t.wn = wn; t.d = d;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        id_valid = t.v; id_rs = t.rs; id_use_rs = t.urs; id_rt = t.rt; id_use_rt = t.urt;
        id_wreg = t.wreg; id_rd = t.rd; id_long = t.lng;
        pipe_we = t.pwe; pipe_wn = t.pwn; pipe_d = t.pd;
        md_valid = t.mv; md_wn = t.mwn; md_d = t.md;
    endtask

    task automatic idle();
        drive(mk(0,0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,1,0,0,0));
    endtask

    vec_t vt[22];

    initial begin
        //        v  rs urs rt urt wr rd lg  pwe pwn pd      mv mwn md       | s r we wn d
        vt[0]  = mk(0, 0,0, 0,0, 0, 0,0,  0, 0,32'h0,   0,0,32'h0,     0,1,0,0,32'h0);
        vt[1]  = mk(1, 0,0, 0,0, 1, 5,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,0,32'h0);
        vt[2]  = mk(1, 5,1, 0,0, 0, 0,0,  0, 0,32'h0,   0,0,32'h0,     1,1,0,0,32'h0);
        vt[3]  = mk(1, 5,1, 0,0, 0, 0,0,  0, 0,32'h0,   1,5,32'h1234,  1,1,1,5,32'h1234);
        vt[4]  = mk(1, 5,1, 0,0, 0, 0,0,  0, 0,32'h0,   0,0,32'h0,     0,1,0,5,32'h1234);
        vt[5]  = mk(1, 0,0, 0,0, 1, 7,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,5,32'h1234);
        vt[6]  = mk(0, 0,0, 0,0, 0, 0,0,  1, 3,32'hAA,  1,7,32'h77,    0,0,1,3,32'hAA);
        vt[7]  = mk(0, 0,0, 0,0, 0, 0,0,  0, 0,32'h0,   1,7,32'h77,    0,1,1,7,32'h77);
        vt[8]  = mk(1, 0,0, 0,0, 1, 1,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,7,32'h77);
        vt[9]  = mk(1, 0,0, 0,0, 1, 2,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,7,32'h77);
        vt[10] = mk(1, 0,0, 0,0, 1, 3,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,7,32'h77);
        vt[11] = mk(1, 0,0, 0,0, 1, 4,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,7,32'h77);
        vt[12] = mk(1, 0,0, 0,0, 1, 8,1,  0, 0,32'h0,   0,0,32'h0,     1,1,0,7,32'h77);
        vt[13] = mk(1, 0,0, 0,0, 1, 8,1,  0, 0,32'h0,   1,1,32'h11,    1,1,1,1,32'h11);
        vt[14] = mk(1, 0,0, 0,0, 1, 8,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,1,32'h11);
        vt[15] = mk(0, 0,0, 0,0, 0, 0,0,  1, 0,32'hBAD, 1,2,32'h22,    0,1,1,2,32'h22);
        vt[16] = mk(1, 0,0, 0,0, 1, 0,1,  0, 0,32'h0,   0,0,32'h0,     0,1,0,2,32'h22);
        vt[17] = mk(1, 0,0, 0,0, 1, 9,1,  0, 0,32'h0,   0,0,32'h0,     1,1,0,2,32'h22);
        vt[18] = mk(1, 0,0, 0,0, 1, 9,1,  0, 0,32'h0,   1,0,32'h99,    1,1,0,2,32'h22);
        vt[19] = mk(1, 0,0, 0,0, 1, 3,0,  0, 0,32'h0,   0,0,32'h0,     1,1,0,2,32'h22);
        vt[20] = mk(1, 0,0, 4,1, 0, 0,0,  0, 0,32'h0,   0,0,32'h0,     1,1,0,2,32'h22);
        vt[21] = mk(1, 4,0, 4,0, 0, 0,0,  0, 0,32'h0,   0,0,32'h0,     0,1,0,2,32'h22);

        idle();
        clrn = 1'b0;
        #1;
        chk("reset_rf_we", 32'(rf_we), 32'h0);
        chk("reset_rf_wn", 32'(rf_wn), 32'h0);
        chk("reset_md_ready", 32'(md_ready), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;

        // Table: drive on falling edge, check combinational outputs, then registered port after the edge.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d_id_stall", i), 32'(id_stall), 32'(vt[i].s));
            chk($sformatf("v%0d_md_ready", i), 32'(md_ready), 32'(vt[i].r));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vt[i].we));
            chk($sformatf("v%0d_rf_wn", i), 32'(rf_wn), 32'(vt[i].wn));
            chk($sformatf("v%0d_rf_d", i), 32'(rf_d), vt[i].d);
        end

        // Starvation: r3,r4,r8 pending, 3 outstanding. MDU result for r3 refused for 8 cycles.
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            drive(mk(1,0,0,0,0,0,0,0, 1,9,32'h900 + 32'(c), 1,3,32'h3333, 0,0,0,0,0));
            #1;
            chk($sformatf("starve_c%0d_stall", c), 32'(id_stall), (c == 9) ? 32'h1 : 32'h0);
            chk($sformatf("starve_c%0d_ready", c), 32'(md_ready), 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("starve_c%0d_rf_wn", c), 32'(rf_wn), 32'h9);
        end
        @(negedge clk);
        drive(mk(1,0,0,0,0,0,0,0, 0,0,32'h0, 1,3,32'h3333, 0,0,0,0,0));
        #1;
        chk("starve_drain_ready", 32'(md_ready), 32'h1);
        chk("starve_drain_stall", 32'(id_stall), 32'h1);
        @(posedge clk);
        #1;
        chk("starve_drain_rf_we", 32'(rf_we), 32'h1);
        chk("starve_drain_rf_wn", 32'(rf_wn), 32'h3);
        chk("starve_drain_rf_d", rf_d, 32'h3333);
        @(negedge clk);
        drive(mk(1,0,0,0,0,0,0,0, 0,0,32'h0, 0,0,32'h0, 0,0,0,0,0));
        #1;
        chk("starve_clear_stall", 32'(id_stall), 32'h0);

        // Reset mid-stream: r4 still pending, pipeline write in flight.
        @(negedge clk);
        drive(mk(0,0,0,0,0,0,0,0, 1,10,32'h5, 0,0,32'h0, 0,0,0,0,0));
        @(posedge clk);
        #1;
        chk("mid_pre_rf_we", 32'(rf_we), 32'h1);
        @(negedge clk);
        drive(mk(1,4,1,0,0,0,0,0, 0,0,32'h0, 0,0,32'h0, 0,0,0,0,0));
        #1;
        chk("mid_pre_stall", 32'(id_stall), 32'h1);
        clrn = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(id_stall), 32'h0);
        chk("mid_rst_rf_we", 32'(rf_we), 32'h0);
        chk("mid_rst_rf_wn", 32'(rf_wn), 32'h0);
        chk("mid_rst_ready", 32'(md_ready), 32'h1);
        chk("mid_rst_pending", dut.u_sb.pending, 32'h0);
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        drive(mk(1,0,0,0,0,1,8,1, 0,0,32'h0, 0,0,32'h0, 0,0,0,0,0));
        #1;
        chk("post_rst_stall", 32'(id_stall), 32'h0);
        @(negedge clk);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule
